// File: rtl/cla_pkg.sv
// Shared types and sizing for the serial carry-lookahead adder; combinational only, no latency.
// No handshake: constants and a sizing helper only, so there is no backpressure.
package cla_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int GROUP_BITS = 4;

   // Index width for WIDTH/4 groups, kept at least 1 bit so WIDTH=4 still builds.
   function automatic int idx_width(input int width);
      return (width / GROUP_BITS > 1) ? $clog2(width / GROUP_BITS) : 1;
   endfunction
endpackage

// File: rtl/cla_slice_4bit.sv
// One 4-bit carry-lookahead group: sum bits, group generate/propagate, carry into bit 3.
// Purely combinational, zero latency; no handshake, so there is no backpressure.
module cla_slice_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c0,
   output logic [3:0] s,
   output logic       G,
   output logic       P,
   output logic       c3
);
   logic [3:0] gen;
   logic [3:0] prp;
   logic [3:0] c;

   assign gen = a & b;
   assign prp = a | b;

   // Every carry is flattened from c0; no carry depends on another carry.
   assign c[0] = c0;
   assign c[1] = gen[0] | (prp[0] & c0);
   assign c[2] = gen[1] | (prp[1] & gen[0]) | (prp[1] & prp[0] & c0);
   assign c[3] = gen[2] | (prp[2] & gen[1]) | (prp[2] & prp[1] & gen[0])
               | (prp[2] & prp[1] & prp[0] & c0);

   assign s  = a ^ b ^ c;
   assign c3 = c[3];
   assign G  = gen[3] | (prp[3] & gen[2]) | (prp[3] & prp[2] & gen[1])
             | (prp[3] & prp[2] & prp[1] & gen[0]);
   assign P  = &prp;
endmodule

// File: rtl/cla_serial_adder32.sv
// Serial adder: one 4-bit lookahead group per cycle; optional overflow via CLA_SERIAL_OVERFLOW_EN.
// Latency WIDTH/4 cycles from accept to done; start is ignored while busy, so it is a drop, not a stall.
module cla_serial_adder32
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int NGROUPS = WIDTH / GROUP_BITS;
   localparam int IW      = idx_width(WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(NGROUPS - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q, cout_q;
   logic [IW-1:0]    idx_q;

   logic [3:0] grp_a, grp_b, grp_s;
   logic       grp_g, grp_p, grp_c3, carry_nxt;
   logic       accept, last_grp;

   assign grp_a     = a_q[idx_q*GROUP_BITS +: GROUP_BITS];
   assign grp_b     = b_q[idx_q*GROUP_BITS +: GROUP_BITS];
   assign carry_nxt = grp_g | (grp_p & carry_q);
   assign accept    = (state_q == IDLE) && start;
   assign last_grp  = (state_q == RUN) && (idx_q == LAST_IDX);

   cla_slice_4bit u_slice (
      .a  (grp_a),
      .b  (grp_b),
      .c0 (carry_q),
      .s  (grp_s),
      .G  (grp_g),
      .P  (grp_p),
      .c3 (grp_c3)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (idx_q == LAST_IDX) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
         end else if (state_q == RUN) begin
            sum_q[idx_q*GROUP_BITS +: GROUP_BITS] <= grp_s;
            carry_q <= carry_nxt;
            idx_q   <= idx_q + 1'b1;
            if (last_grp) cout_q <= carry_nxt;
         end
      end
   end

`ifdef CLA_SERIAL_OVERFLOW_EN
   logic ovf_q;

   // Carry into the MSB differs from carry out of it exactly on signed overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           ovf_q <= 1'b0;
      else if (accept)   ovf_q <= 1'b0;
      else if (last_grp) ovf_q <= grp_c3 ^ carry_nxt;
   end

   assign overflow = ovf_q;
`else
   logic unused_c3;
   assign unused_c3 = grp_c3;
   assign overflow  = 1'b0;
`endif

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_cla_serial_adder32.sv
// Scoreboard bench for cla_serial_adder32: directed corner cases plus random back-to-back adds.
module tb_cla_serial_adder32;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, cin;
   logic [W-1:0] a, b, sum;
   logic         busy, done, cout, overflow;

   cla_serial_adder32 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      int           dcyc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done   = 0;
   int   n_issued = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input int dcyc);
      exp_t         e;
      logic [W:0]   t;
      longint       ss;
      t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      ss = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      e.s  = t[W-1:0];
      e.co = t[W];
`ifdef CLA_SERIAL_OVERFLOW_EN
      e.ov = (ss > 64'sh7FFFFFFF) || (ss < -64'sh80000000);
`else
      e.ov = 1'b0 && (ss == 0);
`endif
      e.dcyc = dcyc;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         n_done++;
         if (q.size() == 0) begin
            chk("spurious_done", 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            chk("sum", {32'd0, sum}, {32'd0, e.s});
            chk("cout", {63'd0, cout}, {63'd0, e.co});
            chk("overflow", {63'd0, overflow}, {63'd0, e.ov});
            chk("latency_cycle", 64'(cyc), 64'(e.dcyc));
         end
      end
   end

   // Called at a negedge; waits for IDLE, presents one start, returns one negedge later.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      int t = 0;
      @(negedge clk);
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("idle_timeout", 64'd1, 64'd0);
      a = x; b = y; cin = ci; start = 1'b1;
      q.push_back(model(x, y, ci, cyc + 1 + W/4));
      n_issued++;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy || q.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("drain_timeout", 64'd1, 64'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_sum", {32'd0, sum}, 64'd0);
      chk("rst_cout", {63'd0, cout}, 64'd0);
      chk("rst_ovf", {63'd0, overflow}, 64'd0);
      rst = 1'b0;

      issue(32'hFFFFFFFF, 32'h00000001, 1'b0);
      chk("busy_after_accept", {63'd0, busy}, 64'd1);
      wait_idle();
      issue(32'h7FFFFFFF, 32'h00000001, 1'b0);
      wait_idle();
      issue(32'h12345678, 32'h0FEDCBA9, 1'b1);
      wait_idle();

      // Starts with different operands mid-RUN must be dropped.
      issue(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0);
      @(negedge clk);
      a = 32'h11111111; b = 32'h22222222; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 32'h33333333; b = 32'h44444444; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Reset halfway through the run abandons the sum.
      issue(32'h76543210, 32'h01234567, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      chk("midrst_sum", {32'd0, sum}, 64'd0);
      chk("midrst_cout", {63'd0, cout}, 64'd0);
      chk("midrst_ovf", {63'd0, overflow}, 64'd0);
      q.delete();
      n_issued--;
      @(negedge clk);
      rst = 1'b0;
      issue(32'h00000001, 32'h00000001, 1'b0);
      wait_idle();

      // Random back-to-back adds.
      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] x, y;
         x = $urandom;
         y = $urandom;
         if (i % 8 == 0) x = 32'hFFFFFFFF;
         if (i % 8 == 1) y = 32'h80000000;
         issue(x, y, 1'($urandom));
      end
      wait_idle();

      chk("queue_empty", 64'(q.size()), 64'd0);
      chk("done_count", 64'(n_done), 64'(n_issued));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end
endmodule
